// File: rtl/audio_pkg.sv
// Shared types for the audio transmit scheduler: FSM state encoding and stereo frame layout.
package audio_pkg;

    localparam int unsigned AUDIO_SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } audio_sched_state_e;

    // Left channel occupies the upper half of a frame word.
    typedef struct packed {
        logic [AUDIO_SAMPLE_W-1:0] left;
        logic [AUDIO_SAMPLE_W-1:0] right;
    } audio_frame_t;

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO with flush; storage is registered and read combinationally at the head.
module audio_frame_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [LW-1:0]    cnt_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (cnt_q == LW'(DEPTH));
    assign empty_o   = (cnt_q == LW'(0));
    assign level_o   = cnt_q;
    assign data_o    = mem_q[rptr_q];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Frame storage; cleared on reset so nothing stale is visible at the head.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s && !flush_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= {PW{1'b0}};
            rptr_q <= {PW{1'b0}};
            cnt_q  <= {LW{1'b0}};
        end else if (flush_i) begin
            wptr_q <= {PW{1'b0}};
            rptr_q <= {PW{1'b0}};
            cnt_q  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop_ok_s) begin
                rptr_q <= rptr_q + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_q <= cnt_q + LW'(1);
                2'b01:   cnt_q <= cnt_q - LW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/audio_tx_sched.sv
// Round-robin stereo frame scheduler feeding an I2S transmitter, with prime/run/drain
// sequencing, underrun counting and a sticky interrupt.
module audio_tx_sched
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic                          stop_i,
    input  logic [2*SAMPLE_W-1:0]         src0_frame_i,
    input  logic                          src0_valid_i,
    output logic                          src0_ready_o,
    input  logic [2*SAMPLE_W-1:0]         src1_frame_i,
    input  logic                          src1_valid_i,
    output logic                          src1_ready_o,
    output logic [SAMPLE_W-1:0]           sample_o,
    output logic                          sample_valid_o,
    input  logic                          sample_ready_i,
    output logic                          tx_enable_o,
    input  logic                          underrun_i,
    input  logic [$clog2(FIFO_DEPTH):0]   lowat_i,
    input  logic                          irq_clr_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          busy_o,
    output logic [CNT_W-1:0]              underrun_cnt_o,
    output logic                          irq_o
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FW = 2 * SAMPLE_W;

    audio_sched_state_e state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               phase_q, phase_d;
    logic               under_prev_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               irq_q, irq_d;

    logic               accept_ok_s;
    logic               grant_s;
    logic               push_s;
    logic [FW-1:0]      push_frame_s;
    logic               pop_s;
    logic               hs_s;
    logic               flush_s;
    logic               full_s;
    logic               empty_s;
    logic [LW-1:0]      level_s;
    logic [LW-1:0]      level_next_s;
    logic [FW-1:0]      head_s;
    logic               uedge_s;
    logic               wm_cross_s;

    audio_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_s),
        .push_i  (push_s),
        .data_i  (push_frame_s),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (level_s)
    );

    // Arbiter: full is the pre-pop value, keeping ready free of any path from sample_ready_i.
    always_comb begin
        accept_ok_s = ((state_q == PRIME) || (state_q == RUN)) && !full_s;
        grant_s     = 1'b0;
        if (src0_valid_i && src1_valid_i) begin
            grant_s = ~last_grant_q;
        end else if (src1_valid_i) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        src0_ready_o = accept_ok_s && !grant_s;
        src1_ready_o = accept_ok_s && grant_s;
        push_s       = accept_ok_s && (grant_s ? src1_valid_i : src0_valid_i);
        push_frame_s = grant_s ? src1_frame_i : src0_frame_i;
        last_grant_d = push_s ? grant_s : last_grant_q;
    end

    // Serialiser: left sample at phase 0, right at phase 1; the right handshake pops the frame.
    always_comb begin
        tx_enable_o    = (state_q == RUN) || (state_q == DRAIN);
        sample_valid_o = tx_enable_o && !empty_s;
        sample_o       = phase_q ? head_s[SAMPLE_W-1:0] : head_s[FW-1:SAMPLE_W];
        hs_s           = sample_valid_o && sample_ready_i;
        pop_s          = hs_s && phase_q;
        if (hs_s) begin
            phase_d = ~phase_q;
        end else begin
            phase_d = phase_q;
        end
    end

    // Next-state logic for the prime/run/drain sequence.
    always_comb begin
        state_d = state_q;
        flush_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !stop_i) state_d = PRIME;
                else                    state_d = IDLE;
            end
            PRIME: begin
                if (stop_i) begin
                    flush_s = 1'b1;
                    state_d = IDLE;
                end else if (full_s || (push_s && (level_s == LW'(FIFO_DEPTH - 1)))) begin
                    state_d = RUN;
                end else begin
                    state_d = PRIME;
                end
            end
            RUN: begin
                if (stop_i) state_d = DRAIN;
                else        state_d = RUN;
            end
            DRAIN: begin
                if (empty_s || (pop_s && (level_s == LW'(1)))) state_d = IDLE;
                else                                           state_d = DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Underrun counting and the sticky interrupt; a set beats a simultaneous clear.
    always_comb begin
        level_next_s = level_s + LW'(push_s) - LW'(pop_s);
        uedge_s      = underrun_i && !under_prev_q && tx_enable_o;
        wm_cross_s   = (state_q == RUN) && (level_s >= lowat_i) && (level_next_s < lowat_i);
        if (uedge_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (uedge_s || wm_cross_s) begin
            irq_d = 1'b1;
        end else if (irq_clr_i) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            phase_q      <= 1'b0;
            under_prev_q <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            phase_q      <= phase_d;
            under_prev_q <= underrun_i;
            cnt_q        <= cnt_d;
            irq_q        <= irq_d;
        end
    end

    assign busy_o         = (state_q != IDLE);
    assign level_o        = level_s;
    assign underrun_cnt_o = cnt_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_audio_tx_sched.sv
// Directed self-checking bench for audio_tx_sched; a second instance with a 2-bit
// underrun counter shares all stimulus to observe counter saturation.
module tb_audio_tx_sched;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i, stop_i;
    logic [31:0] src0_frame_i, src1_frame_i;
    logic        src0_valid_i, src1_valid_i;
    logic        sample_ready_i, underrun_i, irq_clr_i;
    logic [2:0]  lowat_i;

    logic        src0_ready_o, src1_ready_o, sample_valid_o, tx_enable_o, busy_o, irq_o;
    logic [15:0] sample_o, underrun_cnt_o;
    logic [2:0]  level_o;

    logic        b_src0_ready, b_src1_ready, b_sample_valid, b_tx_enable, b_busy, b_irq;
    logic [15:0] b_sample;
    logic [1:0]  b_cnt;
    logic [2:0]  b_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    audio_tx_sched #(.SAMPLE_W(16), .FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
        .src0_frame_i(src0_frame_i), .src0_valid_i(src0_valid_i), .src0_ready_o(src0_ready_o),
        .src1_frame_i(src1_frame_i), .src1_valid_i(src1_valid_i), .src1_ready_o(src1_ready_o),
        .sample_o(sample_o), .sample_valid_o(sample_valid_o), .sample_ready_i(sample_ready_i),
        .tx_enable_o(tx_enable_o), .underrun_i(underrun_i), .lowat_i(lowat_i),
        .irq_clr_i(irq_clr_i), .level_o(level_o), .busy_o(busy_o),
        .underrun_cnt_o(underrun_cnt_o), .irq_o(irq_o)
    );

    audio_tx_sched #(.SAMPLE_W(16), .FIFO_DEPTH(4), .CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
        .src0_frame_i(src0_frame_i), .src0_valid_i(src0_valid_i), .src0_ready_o(b_src0_ready),
        .src1_frame_i(src1_frame_i), .src1_valid_i(src1_valid_i), .src1_ready_o(b_src1_ready),
        .sample_o(b_sample), .sample_valid_o(b_sample_valid), .sample_ready_i(sample_ready_i),
        .tx_enable_o(b_tx_enable), .underrun_i(underrun_i), .lowat_i(lowat_i),
        .irq_clr_i(irq_clr_i), .level_o(b_level), .busy_o(b_busy),
        .underrun_cnt_o(b_cnt), .irq_o(b_irq)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},  busy_o, 64'd0);
        check_eq({tag, "_txen"},  tx_enable_o, 64'd0);
        check_eq({tag, "_sval"},  sample_valid_o, 64'd0);
        check_eq({tag, "_samp"},  sample_o, 64'd0);
        check_eq({tag, "_lvl"},   level_o, 64'd0);
        check_eq({tag, "_cnt"},   underrun_cnt_o, 64'd0);
        check_eq({tag, "_irq"},   irq_o, 64'd0);
        check_eq({tag, "_rdy0"},  src0_ready_o, 64'd0);
        check_eq({tag, "_rdy1"},  src1_ready_o, 64'd0);
        check_eq({tag, "_cnt2"},  b_cnt, 64'd0);
    endtask

    logic [31:0] prime_frames [4] = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    logic [15:0] prime_samples [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                                       16'h5555, 16'h6666, 16'h7777, 16'h8888};
    logic [15:0] drain_samples [6] = '{16'hBBBB, 16'h0000, 16'hAAAA, 16'h0000, 16'hBBBB, 16'h0000};

    initial begin
        logic exp_g;
        rst_ni = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        src0_frame_i = 32'h0; src1_frame_i = 32'h0; src0_valid_i = 1'b0; src1_valid_i = 1'b0;
        sample_ready_i = 1'b0; underrun_i = 1'b0; irq_clr_i = 1'b0; lowat_i = 3'd0;

        // Reset values
        repeat (3) tick();
        check_all_zero("reset");
        rst_ni = 1'b1;
        tick();

        // Prime then run
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        settle();
        check_eq("prime_busy", busy_o, 64'd1);
        check_eq("prime_txen", tx_enable_o, 64'd0);
        src0_valid_i = 1'b1;
        sample_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src0_frame_i = prime_frames[i];
            settle();
            check_eq("prime_rdy0", src0_ready_o, 64'd1);
            check_eq("prime_sval", sample_valid_o, 64'd0);
            tick();
        end
        src0_valid_i = 1'b0;
        settle();
        check_eq("run_txen", tx_enable_o, 64'd1);
        check_eq("run_sval", sample_valid_o, 64'd1);
        check_eq("run_lvl", level_o, 64'd4);
        for (int k = 0; k < 8; k++) begin
            check_eq("run_sample", sample_o, 64'(prime_samples[k]));
            check_eq("run_sample_v", sample_valid_o, 64'd1);
            tick();
            settle();
        end
        check_eq("run_empty_sval", sample_valid_o, 64'd0);
        check_eq("run_empty_lvl", level_o, 64'd0);

        // Round-robin, src0 took the last grant so src1 wins the first tie
        sample_ready_i = 1'b0;
        src0_frame_i = 32'hAAAA_0000; src1_frame_i = 32'hBBBB_0000;
        src0_valid_i = 1'b1; src1_valid_i = 1'b1;
        settle();
        exp_g = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check_eq("rr_rdy0", src0_ready_o, 64'(!exp_g));
            check_eq("rr_rdy1", src1_ready_o, 64'(exp_g));
            tick();
            exp_g = ~exp_g;
            settle();
        end

        // Backpressure at full
        check_eq("bp_rdy0", src0_ready_o, 64'd0);
        check_eq("bp_rdy1", src1_ready_o, 64'd0);
        check_eq("bp_lvl", level_o, 64'd4);
        tick();
        settle();
        check_eq("bp_hold_rdy0", src0_ready_o, 64'd0);
        check_eq("bp_hold_rdy1", src1_ready_o, 64'd0);
        check_eq("bp_hold_lvl", level_o, 64'd4);
        sample_ready_i = 1'b1;
        settle();
        check_eq("bp_left", sample_o, 64'hBBBB);
        tick();
        settle();
        check_eq("bp_right", sample_o, 64'h0000);
        check_eq("bp_ph1_rdy0", src0_ready_o, 64'd0);
        check_eq("bp_ph1_rdy1", src1_ready_o, 64'd0);
        check_eq("bp_ph1_lvl", level_o, 64'd4);
        tick();
        sample_ready_i = 1'b0;
        settle();
        check_eq("bp_pop_lvl", level_o, 64'd3);
        check_eq("bp_pop_rdy1", src1_ready_o, 64'd1);
        check_eq("bp_pop_rdy0", src0_ready_o, 64'd0);
        tick();
        src0_valid_i = 1'b0; src1_valid_i = 1'b0;
        settle();
        check_eq("bp_refill_lvl", level_o, 64'd4);

        // Drain: FIFO holds A,B,A,B; pop one frame, then stop with three held
        sample_ready_i = 1'b1;
        settle();
        check_eq("dr_first", sample_o, 64'hAAAA);
        tick();
        tick();
        sample_ready_i = 1'b0;
        stop_i = 1'b1;
        settle();
        check_eq("dr_lvl3", level_o, 64'd3);
        tick();
        stop_i = 1'b0;
        src0_valid_i = 1'b1;
        sample_ready_i = 1'b1;
        settle();
        check_eq("dr_busy", busy_o, 64'd1);
        for (int k = 0; k < 6; k++) begin
            check_eq("dr_sample", sample_o, 64'(drain_samples[k]));
            check_eq("dr_sval", sample_valid_o, 64'd1);
            check_eq("dr_txen", tx_enable_o, 64'd1);
            check_eq("dr_rdy0", src0_ready_o, 64'd0);
            check_eq("dr_rdy1", src1_ready_o, 64'd0);
            tick();
            settle();
        end
        check_eq("dr_idle_busy", busy_o, 64'd0);
        check_eq("dr_idle_txen", tx_enable_o, 64'd0);
        check_eq("dr_idle_sval", sample_valid_o, 64'd0);
        src0_valid_i = 1'b0;
        sample_ready_i = 1'b0;

        // Underrun edges while disabled are not counted
        underrun_i = 1'b1;
        tick();
        underrun_i = 1'b0;
        tick();
        settle();
        check_eq("ur_idle_cnt", underrun_cnt_o, 64'd0);
        check_eq("ur_idle_irq", irq_o, 64'd0);

        // Back to RUN with a full FIFO
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        src0_valid_i = 1'b1;
        src0_frame_i = 32'h1234_5678;
        repeat (4) tick();
        src0_valid_i = 1'b0;
        settle();
        check_eq("ur_run_txen", tx_enable_o, 64'd1);
        check_eq("ur_run_lvl", level_o, 64'd4);

        for (int i = 0; i < 3; i++) begin
            underrun_i = 1'b1;
            tick();
            underrun_i = 1'b0;
            tick();
        end
        settle();
        check_eq("ur_cnt3", underrun_cnt_o, 64'd3);
        check_eq("ur_irq", irq_o, 64'd1);
        check_eq("ur_cnt2_3", b_cnt, 64'd3);
        irq_clr_i = 1'b1;
        tick();
        irq_clr_i = 1'b0;
        settle();
        check_eq("ur_clr", irq_o, 64'd0);
        underrun_i = 1'b1;
        irq_clr_i = 1'b1;
        tick();
        underrun_i = 1'b0;
        irq_clr_i = 1'b0;
        settle();
        check_eq("ur_set_wins", irq_o, 64'd1);
        check_eq("ur_cnt4", underrun_cnt_o, 64'd4);
        tick();
        irq_clr_i = 1'b1;
        tick();
        irq_clr_i = 1'b0;
        underrun_i = 1'b1;
        tick();
        underrun_i = 1'b0;
        settle();
        check_eq("ur_cnt5", underrun_cnt_o, 64'd5);
        check_eq("ur_sat", b_cnt, 64'd3);
        check_eq("ur_irq5", irq_o, 64'd1);
        irq_clr_i = 1'b1;
        tick();
        irq_clr_i = 1'b0;
        settle();
        check_eq("ur_clr2", irq_o, 64'd0);

        // Low watermark crossing 2 -> 1 in RUN
        lowat_i = 3'd2;
        sample_ready_i = 1'b1;
        repeat (4) tick();
        settle();
        check_eq("wm_lvl2", level_o, 64'd2);
        check_eq("wm_irq_lo", irq_o, 64'd0);
        repeat (2) tick();
        settle();
        check_eq("wm_lvl1", level_o, 64'd1);
        check_eq("wm_irq_set", irq_o, 64'd1);
        sample_ready_i = 1'b0;
        settle();
        check_eq("wm_pre_rst_txen", tx_enable_o, 64'd1);

        // Asynchronous reset mid-RUN
        #1;
        rst_ni = 1'b0;
        #1;
        check_all_zero("arst");
        tick();
        rst_ni = 1'b1;
        tick();

        // First tie after reset goes to src0
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        src0_valid_i = 1'b1; src1_valid_i = 1'b1;
        settle();
        check_eq("tie0_rdy0", src0_ready_o, 64'd1);
        check_eq("tie0_rdy1", src1_ready_o, 64'd0);
        tick();
        settle();
        check_eq("tie1_rdy1", src1_ready_o, 64'd1);
        check_eq("tie1_rdy0", src0_ready_o, 64'd0);
        src0_valid_i = 1'b0; src1_valid_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
